cl_ocl_cfg_xbar: RTL and testbench

//  AXI4-Lite slave on the OCL BAR that decodes each access onto one of NUM_SLV cfg-bus targets.

---
 rtl/cl_ocl_cfg_xbar.sv | 193 +++++++++++++++++++
 tb/tb_cl_ocl_cfg_xbar.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_ocl_cfg_xbar.sv
// AXI4-Lite slave on the OCL BAR that decodes each access onto one of NUM_SLV cfg-bus targets.
// One access in flight; read/write round-robin, ack timeout (SLVERR), DECERR, FLR abort.
//
// state  | meaning
// S_IDLE | waiting for AW+W or AR, grant made combinationally
// S_REQ  | cfg_wr/cfg_rd pulse to the selected target (or DECERR if unmapped)
// S_WAIT | waiting for cfg_ack[idx] or the ack timeout
// S_RESP | B or R response held until the master accepts it
module cl_ocl_cfg_xbar #(
    parameter int NUM_SLV      = 16,
    parameter int SLV_WIN_BITS = 8,
    parameter int TIMEOUT_CYC  = 256,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    sync_rst,
    input  logic                    flr_assert,
    input  logic [31:0]             s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [31:0]             s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [NUM_SLV*32-1:0]   cfg_addr,
    output logic [NUM_SLV*32-1:0]   cfg_wdata,
    output logic [NUM_SLV*4-1:0]    cfg_wstrb,
    output logic [NUM_SLV-1:0]      cfg_wr,
    output logic [NUM_SLV-1:0]      cfg_rd,
    input  logic [NUM_SLV-1:0]      cfg_ack,
    input  logic [NUM_SLV*32-1:0]   cfg_rdata,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [31:0] ERR_DATA    = 32'hdead_beef;
    localparam int          CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int          TO_LAST     = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    state_t             state;
    logic               rr_rd_next;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_wstrb;
    logic               lat_wr;
    logic               lat_in_range;
    logic [5:0]         idx;
    logic [CNT_W-1:0]   cnt;

    logic               wr_pend, rd_pend, can_grant, grant_wr, grant_rd;
    logic [31:0]        grant_addr;
    logic [5:0]         grant_idx;
    logic               grant_in_range;
    logic [63:0]        grant_sel;
    logic [63:0]        ack_pad;
    logic [63:0][31:0]  rdata_pad;

    // Targets are padded out to the full 6-bit index space so idx never selects past the ports.
    always_comb begin
        ack_pad   = '0;
        rdata_pad = '0;
        ack_pad[NUM_SLV-1:0] = cfg_ack;
        for (int i = 0; i < NUM_SLV; i++) begin
            rdata_pad[i] = cfg_rdata[i*32 +: 32];
        end
    end

    assign wr_pend        = s_awvalid & s_wvalid;
    assign rd_pend        = s_arvalid;
    assign can_grant      = (state == S_IDLE) & ~flr_assert & ~sync_rst;
    assign grant_wr       = can_grant & wr_pend & (~rd_pend | ~rr_rd_next);
    assign grant_rd       = can_grant & rd_pend & (~wr_pend |  rr_rd_next);
    assign grant_addr     = grant_wr ? s_awaddr : s_araddr;
    assign grant_idx      = grant_addr[SLV_WIN_BITS +: 6];
    assign grant_in_range = ({26'd0, grant_idx} < 32'(NUM_SLV));
    assign grant_sel      = 64'd1 << grant_idx;

    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;

    assign cfg_addr  = {NUM_SLV{lat_addr}};
    assign cfg_wdata = {NUM_SLV{lat_wdata}};
    assign cfg_wstrb = {NUM_SLV{lat_wstrb}};

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state        <= S_IDLE;
            rr_rd_next   <= 1'b1;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_wstrb    <= '0;
            lat_wr       <= 1'b0;
            lat_in_range <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
            cfg_wr       <= '0;
            cfg_rd       <= '0;
            s_bvalid     <= 1'b0;
            s_rvalid     <= 1'b0;
            s_bresp      <= RESP_OKAY;
            s_rresp      <= RESP_OKAY;
            s_rdata      <= '0;
            err_cnt      <= '0;
        end else if (flr_assert) begin
            state    <= S_IDLE;
            cfg_wr   <= '0;
            cfg_rd   <= '0;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            cnt      <= '0;
        end else begin
            cfg_wr <= '0;
            cfg_rd <= '0;
            unique case (state)
                S_IDLE: begin
                    if (grant_wr || grant_rd) begin
                        lat_addr     <= grant_addr;
                        lat_wdata    <= s_wdata;
                        lat_wstrb    <= s_wstrb;
                        lat_wr       <= grant_wr;
                        lat_in_range <= grant_in_range;
                        idx          <= grant_idx;
                        rr_rd_next   <= grant_wr;
                        cnt          <= '0;
                        if (grant_in_range) begin
                            if (grant_wr) cfg_wr <= grant_sel[NUM_SLV-1:0];
                            else          cfg_rd <= grant_sel[NUM_SLV-1:0];
                        end
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (lat_in_range) begin
                        state <= S_WAIT;
                    end else begin
                        s_bresp  <= RESP_DECERR;
                        s_rresp  <= RESP_DECERR;
                        s_rdata  <= ERR_DATA;
                        s_bvalid <= lat_wr;
                        s_rvalid <= ~lat_wr;
                        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                        state <= S_RESP;
                    end
                end
                S_WAIT: begin
                    // Ack has priority over a timeout landing in the same cycle.
                    if (ack_pad[idx]) begin
                        s_bresp  <= RESP_OKAY;
                        s_rresp  <= RESP_OKAY;
                        s_rdata  <= rdata_pad[idx];
                        s_bvalid <= lat_wr;
                        s_rvalid <= ~lat_wr;
                        state    <= S_RESP;
                    end else if (TIMEOUT_CYC != 0 && cnt == CNT_W'(TO_LAST)) begin
                        s_bresp  <= RESP_SLVERR;
                        s_rresp  <= RESP_SLVERR;
                        s_rdata  <= ERR_DATA;
                        s_bvalid <= lat_wr;
                        s_rvalid <= ~lat_wr;
                        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
                        s_bvalid <= 1'b0;
                        s_rvalid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cl_ocl_cfg_xbar.sv
// Directed bench for cl_ocl_cfg_xbar: a behavioural target model acks after a per-target delay,
// and each access is checked against hand-computed responses.
module tb_cl_ocl_cfg_xbar;

    localparam int NS = 16;

    logic               clk = 1'b0;
    logic               sync_rst, flr_assert;
    logic [31:0]        s_awaddr, s_wdata, s_araddr;
    logic [3:0]         s_wstrb;
    logic               s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]         s_bresp, s_rresp;
    logic               s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0]        s_rdata;
    logic [NS*32-1:0]   cfg_addr, cfg_wdata, cfg_rdata;
    logic [NS*4-1:0]    cfg_wstrb;
    logic [NS-1:0]      cfg_wr, cfg_rd, cfg_ack;
    logic [15:0]        err_cnt;

    logic [NS-1:0]      resp_ack = '0;
    logic [NS-1:0]      manual_ack = '0;
    int                 ack_delay [NS];
    int                 cd [NS];
    int                 wr_pulses [NS];
    int                 rd_pulses [NS];
    logic [31:0]        last_addr [NS];
    logic [31:0]        last_wdata [NS];
    logic [3:0]         last_wstrb [NS];

    int n_tests = 0;
    int n_fail  = 0;

    assign cfg_ack = resp_ack | manual_ack;

    always #5 clk = ~clk;

    cl_ocl_cfg_xbar #(
        .NUM_SLV(NS), .SLV_WIN_BITS(8), .TIMEOUT_CYC(8), .ERR_CNT_W(16)
    ) dut (
        .clk(clk), .sync_rst(sync_rst), .flr_assert(flr_assert),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wstrb(cfg_wstrb),
        .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
        .err_cnt(err_cnt)
    );

    // Target model: ack_delay[i] cycles after a pulse, ack for one cycle; 0 means never ack.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            resp_ack[i] <= 1'b0;
            if (cfg_wr[i]) wr_pulses[i] = wr_pulses[i] + 1;
            if (cfg_rd[i]) rd_pulses[i] = rd_pulses[i] + 1;
            if (cfg_wr[i] || cfg_rd[i]) begin
                last_addr[i]  = cfg_addr[i*32 +: 32];
                last_wdata[i] = cfg_wdata[i*32 +: 32];
                last_wstrb[i] = cfg_wstrb[i*4 +: 4];
                cd[i] = ack_delay[i];
            end else if (cd[i] > 0) begin
                if (cd[i] == 1) resp_ack[i] <= 1'b1;
                cd[i] = cd[i] - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int i = 0; i < NS; i++) s += wr_pulses[i] + rd_pulses[i];
        return s;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        resp = 2'b01;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_awready && n < 50);
        check("aw_w_grant", {s_awready, s_wready}, 2'b11);
        if (!s_awready) begin s_awvalid = 1'b0; s_wvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_bvalid && n < 50);
        if (!s_bvalid) begin check("b_valid_timeout", 0, 1); return; end
        resp = s_bresp;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold, output logic [1:0] resp,
                            output logic [31:0] data, output int lat);
        int n;
        resp = 2'b01; data = '0; lat = 0;
        s_araddr = addr; s_arvalid = 1'b1;
        if (hold > 0) s_rready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_arready && n < 50);
        if (!s_arready) begin check("ar_grant_timeout", 0, 1); s_arvalid = 1'b0; s_rready = 1'b1; return; end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        do begin @(negedge clk); lat++; end while (!s_rvalid && lat < 50);
        if (!s_rvalid) begin check("r_valid_timeout", 0, 1); s_rready = 1'b1; return; end
        resp = s_rresp; data = s_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_hold_stable", {s_rvalid, s_rresp, s_rdata}, {1'b1, resp, data});
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat, p0, ng, cyc;
        logic        seen;
        logic        g [4];

        for (int i = 0; i < NS; i++) begin
            cfg_rdata[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
            ack_delay[i] = 1;
        end
        cfg_rdata[3*32 +: 32] = 32'h1234_5678;
        ack_delay[1] = 3; ack_delay[2] = 0; ack_delay[3] = 2;

        sync_rst = 1'b1; flr_assert = 1'b0;
        s_awaddr = 32'h104; s_wdata = '0; s_wstrb = '0; s_araddr = 32'h310;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        s_bready = 1'b1; s_rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readies", {s_awready, s_wready, s_arready}, 3'b000);
        check("rst_valids", {s_bvalid, s_rvalid}, 2'b00);
        check("rst_out", {s_bresp, s_rresp, s_rdata}, '0);
        check("rst_cfg", {cfg_wr, cfg_rd, cfg_addr[63:0]}, '0);
        check("rst_err_cnt", err_cnt, 16'd0);
        @(posedge clk); #1;
        sync_rst = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;

        // Write to target 1, acked after 3 cycles
        axi_write(32'h0000_0105, 32'hA5A5_5A5A, 4'hF, resp);
        check("wr1_bresp", resp, 2'b00);
        check("wr1_pulse", wr_pulses[1], 1);
        check("wr1_rd_none", total_pulses(), 1);
        check("wr1_addr", last_addr[1], 32'h0000_0105);
        check("wr1_data", {last_wdata[1], last_wstrb[1]}, {32'hA5A5_5A5A, 4'hF});

        // Read target 3 with master back-pressure on R
        axi_read(32'h0000_0310, 3, resp, data, lat);
        check("rd3_rresp", resp, 2'b00);
        check("rd3_rdata", data, 32'h1234_5678);
        check("rd3_pulse", rd_pulses[3], 1);

        // Unmapped window (idx 63) and first unmapped index (16)
        p0 = total_pulses();
        axi_read(32'h0000_FF00, 0, resp, data, lat);
        check("dec_rd_resp", {resp, data}, {2'b11, 32'hdead_beef});
        check("dec_rd_err_cnt", err_cnt, 16'd1);
        axi_write(32'h0000_1000, 32'h1, 4'h1, resp);
        check("dec_wr_resp", resp, 2'b11);
        check("dec_no_pulse", total_pulses(), p0);
        check("dec_wr_err_cnt", err_cnt, 16'd2);

        // Highest mapped index
        axi_read(32'h0000_0F00, 0, resp, data, lat);
        check("rd15", {resp, data}, {2'b00, 32'hC0DE_000F});

        // Timeout: 1 REQ + 8 WAIT cycles, response seen on the 10th negedge after grant
        axi_read(32'h0000_0200, 0, resp, data, lat);
        check("to_resp", {resp, data}, {2'b10, 32'hdead_beef});
        check("to_latency", lat, 10);
        check("to_err_cnt", err_cnt, 16'd3);
        manual_ack[2] = 1'b1;
        @(posedge clk); #1;
        manual_ack[2] = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", {s_bvalid, s_rvalid}, 2'b00);
        @(posedge clk); #1;
        axi_read(32'h0000_0310, 0, resp, data, lat);
        check("after_to_rd", {resp, data}, {2'b00, 32'h1234_5678});
        check("after_to_err_cnt", err_cnt, 16'd3);

        // Both pending continuously: last grant was a read, so W,R,W,R
        s_awaddr = 32'h104; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF; s_araddr = 32'h314;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        p0 = wr_pulses[1] + rd_pulses[3];
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (s_awready) begin g[ng] = 1'b1; ng++; end
            else if (s_arready) begin g[ng] = 1'b0; ng++; end
            if (ng == 4) begin
                @(posedge clk); #1;
                s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
            end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check("arb_count", ng, 4);
        if (ng == 4) check("arb_order", {g[0], g[1], g[2], g[3]}, 4'b1010);
        repeat (12) @(posedge clk); #1;
        check("arb_pulses", wr_pulses[1] + rd_pulses[3], p0 + 4);

        // FLR during WAIT: no response, err_cnt kept
        s_awaddr = 32'h208; s_wdata = 32'h1111_2222; s_wstrb = 4'h3;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!s_awready && cyc < 50);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        repeat (3) @(posedge clk); #1;
        flr_assert = 1'b1;
        @(posedge clk); #1;
        flr_assert = 1'b0;
        seen = 1'b0;
        repeat (15) begin @(negedge clk); if (s_bvalid || s_rvalid) seen = 1'b1; end
        check("flr_no_resp", seen, 1'b0);
        check("flr_err_cnt", err_cnt, 16'd3);
        check("flr_wstrb_pass", {last_wdata[2], last_wstrb[2]}, {32'h1111_2222, 4'h3});
        @(posedge clk); #1;
        flr_assert = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(negedge clk);
        check("flr_no_ready", {s_awready, s_wready, s_arready}, 3'b000);
        @(posedge clk); #1;
        flr_assert = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        axi_write(32'h0000_0100, 32'hCAFE_F00D, 4'hC, resp);
        check("after_flr_wr", resp, 2'b00);

        // sync_rst mid-transaction: response never issued, state and counters cleared
        s_araddr = 32'h200; s_arvalid = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!s_arready && cyc < 50);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        repeat (3) @(posedge clk); #1;
        sync_rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        sync_rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin @(negedge clk); if (s_bvalid || s_rvalid) seen = 1'b1; end
        check("rst_mid_no_resp", seen, 1'b0);
        check("rst_mid_err_cnt", err_cnt, 16'd0);
        @(posedge clk); #1;
        s_awaddr = 32'h104; s_araddr = 32'h310;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(negedge clk);
        check("rr_after_rst", {s_awready, s_arready}, 2'b01);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
